serial_sub: RTL
===============

// Module: serial_sub
// PURPOSE
//  Multi-cycle unsigned subtractor computing diff = a - b - bin, BITS_PER_CYCLE bits/cycle, LSB first,
//  with a registered borrow between steps. Counterpart of the ripple full-adder datapath in the
//  arithmetic library: area-lean subtraction for iterative dividers and compare units.
//  Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  WIDTH           16  operand/result width in bits (>=2)
//  BITS_PER_CYCLE  1   bits resolved per clock; must divide WIDTH (elaboration error otherwise)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend (unsigned)
//  b          in   WIDTH  subtrahend (unsigned)
//  bin        in   1      borrow-in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  (a - b - bin) mod 2^WIDTH (see CONFIGURATION)
//  bout       out  1      final borrow: 1 iff a < b + bin
//  zero       out  1      diff == 0
// BEHAVIOUR
//  - STEPS = WIDTH/BITS_PER_CYCLE. FSM states: IDLE, BUSY, DONE.
//  - Reset: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, zero=0, counter=0, borrow reg=0.
//  - IDLE: in_ready=1. On in_valid&in_ready: latch a,b into shift regs, borrow reg<=bin, count<=0 -> BUSY.
//  - BUSY: in_ready=0, out_valid=0. Each cycle the BITS_PER_CYCLE LSBs of a,b plus borrow reg pass through
//    a chain of fsub; results shift into result reg from the top; a,b shift right; borrow reg <= chain bout;
//    count++. When count==STEPS-1 the final step completes -> DONE.
//  - DONE: out_valid=1; diff/bout/zero stable and held until out_ready=1; then -> IDLE (out_valid drops next cycle).
//  - Latency: handshake accepted at edge t -> out_valid high in cycle after edge t+STEPS. Min issue interval STEPS+2.
//  - in_valid in BUSY/DONE ignored (in_ready=0); operands not sampled. Operand changes after accept no effect.
//  - diff/bout/zero only meaningful while out_valid=1; they hold their last value otherwise.
//  - Wrap-around: a<b+bin yields modular diff and bout=1; a=b, bin=0 gives diff=0, zero=1, bout=0.
//  - rst in any state (incl. mid-BUSY or DONE) aborts: in-flight result discarded, all outputs to reset values.
//  - rst has priority over every handshake in the same cycle.
// CONFIGURATION
//  SERIAL_SUB_SAT_EN defined: on final bout=1, diff forced to 0 and zero=1; bout still reports 1 (saturate to 0).
//  SERIAL_SUB_SAT_EN undefined: diff is the wrapped modular result, zero reflects it. Timing/handshake identical.
// STRUCTURE
//  serial_sub_pkg: state typedef (IDLE/BUSY/DONE), function clog2-based counter width, STEPS constant helper.
//  Sub-module fsub (a,b,bin -> d,bout): d=a^b^bin, bout=(~a&b)|(~(a^b)&bin); BITS_PER_CYCLE instances chained
//  via generate. No other hierarchy.
// TESTING (WIDTH=8 unless stated)
//  1. a=0x5A b=0x23 bin=0, BPC=1 -> diff=0x37 bout=0 zero=0; out_valid exactly 8 cycles after accept edge.
//  2. a=0x10 b=0x20 bin=0 -> diff=0xF0 bout=1 zero=0; with SERIAL_SUB_SAT_EN: diff=0x00 bout=1 zero=1.
//  3. a=0x01 b=0x00 bin=1 -> diff=0x00 bout=0 zero=1.
//  4. out_ready held low 5 cycles in DONE, in_valid pulsed -> diff/bout stable, in_ready=0, no new capture;
//     out_ready=1 -> IDLE, in_ready=1 next cycle.
//  5. rst asserted on 4th BUSY cycle -> out_valid never rises, outputs at reset values next cycle;
//     following op a=0xFF b=0x01 bin=0 -> diff=0xFE bout=0.
//  6. BPC=4, a=0x00 b=0xFF bin=1 -> diff=0x00 bout=1 zero=1, out_valid 2 cycles after accept.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int steps_of(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Step counter must hold 0..steps-1; keep at least one bit.
  function automatic int cnt_width(input int steps);
    return (steps < 2) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_sub_fsub.sv
// One-bit full subtractor cell: d = a - b - bin with borrow-out.
module fsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle unsigned subtractor, BITS_PER_CYCLE bits per clock, LSB first.
// Optional saturate-to-zero on final borrow: define SERIAL_SUB_SAT_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int STEPS = steps_of(WIDTH, BITS_PER_CYCLE);
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_sub: WIDTH must be at least 2");
  end
  if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("serial_sub: BITS_PER_CYCLE must divide WIDTH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic [BITS_PER_CYCLE:0]         chain_b;
  logic [BITS_PER_CYCLE-1:0]       chain_d;
  logic [WIDTH+BITS_PER_CYCLE-1:0] res_ext;
  logic [WIDTH-1:0]                res_shift;

  assign chain_b[0] = borrow_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
    fsub u_fsub (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .bin  (chain_b[i]),
      .d    (chain_d[i]),
      .bout (chain_b[i+1])
    );
  end

  // New digits enter at the top so the LSB-first result lands in place after STEPS shifts.
  assign res_ext   = {chain_d, res_q};
  assign res_shift = WIDTH'(res_ext >> BITS_PER_CYCLE);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        a_d      = a_q >> BITS_PER_CYCLE;
        b_d      = b_q >> BITS_PER_CYCLE;
        borrow_d = chain_b[BITS_PER_CYCLE];
        res_d    = res_shift;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = chain_b[BITS_PER_CYCLE];
`ifdef SERIAL_SUB_SAT_EN
          if (chain_b[BITS_PER_CYCLE]) begin
            diff_d = '0;
            zero_d = 1'b1;
          end else begin
            diff_d = res_shift;
            zero_d = (res_shift == '0);
          end
`else
          diff_d = res_shift;
          zero_d = (res_shift == '0);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

endmodule
